control_unit: RTL and testbench



---
 rtl/control_unit.sv | 181 ++++++++++++++++++
 tb/tb_control_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// rtl/control_unit.sv - four-phase instruction sequencer and datapath control decode
//
// Captures a 4-bit opcode into an internal IR at the end of DECODE, then steps
// FETCH -> DECODE -> EXECUTE -> WRITEBACK and drives the datapath control
// lines as a pure Moore decode of (state, IR).
//
// Ports:
//   clk        system clock, rising-edge active
//   rst        synchronous active-high reset (priority over everything)
//   en         run enable, honoured only in IDLE and at the WRITEBACK boundary
//   OP         opcode from the instruction word, sampled leaving DECODE
//   clk_out    datapath phase clock, high in EXECUTE and WRITEBACK
//   immed_sel  ALU B / PC target from immediate (1) or register (0)
//   w_en       register-file write enable (WRITEBACK only)
//   alu_func   ALU operation code (0 = PASS_B)
//   flag_en    flag-register load enable (EXECUTE only)
//   mem_sel    register write data from memory (1) or ALU (0)
//   mem_en     data-memory write enable (EXECUTE only)
//   pc_sel     PC next = target (1) or PC+1 (0)
//   mar_sel    MAR source = immediate address (1) or PC (0)

module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] OP,
    output logic       clk_out,
    output logic       immed_sel,
    output logic       w_en,
    output logic [3:0] alu_func,
    output logic       flag_en,
    output logic       mem_sel,
    output logic       mem_en,
    output logic       pc_sel,
    output logic       mar_sel
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_LD   = 4'hB;
    localparam logic [3:0] OP_ST   = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_CMP  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [3:0] ALU_PASS_B = 4'h0;
    localparam logic [3:0] ALU_ADD    = 4'h1;
    localparam logic [3:0] ALU_SUB    = 4'h2;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] ir;

    // ALU-class opcodes share one strobe pattern; alu_func is the opcode itself.
    logic is_alu_op;
    assign is_alu_op = (ir >= OP_ADD) && (ir <= OP_SHR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ir    <= OP_NOP;
        end else begin
            state <= state_next;
            // IR is loaded on the edge that leaves DECODE, so EXECUTE already
            // sees the new opcode and OP is ignored at every other edge.
            if (state == S_DECODE) begin
                ir <= OP;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      state_next = en ? S_FETCH : S_IDLE;
            S_FETCH:     state_next = S_DECODE;
            S_DECODE:    state_next = S_EXECUTE;
            S_EXECUTE:   state_next = (ir == OP_HLT) ? S_HALT : S_WRITEBACK;
            S_WRITEBACK: state_next = en ? S_FETCH : S_IDLE;
            S_HALT:      state_next = S_HALT;
            default:     state_next = S_IDLE;
        endcase
    end

    always_comb begin
        clk_out   = 1'b0;
        immed_sel = 1'b0;
        w_en      = 1'b0;
        alu_func  = ALU_PASS_B;
        flag_en   = 1'b0;
        mem_sel   = 1'b0;
        mem_en    = 1'b0;
        pc_sel    = 1'b0;
        mar_sel   = 1'b0;

        case (state)
            S_EXECUTE: begin
                clk_out = 1'b1;
                if (is_alu_op) begin
                    alu_func = ir;
                    flag_en  = 1'b1;
                end else begin
                    case (ir)
                        OP_ADDI: begin
                            alu_func  = ALU_ADD;
                            immed_sel = 1'b1;
                            flag_en   = 1'b1;
                        end
                        OP_LDI: begin
                            immed_sel = 1'b1;
                        end
                        OP_LD: begin
                            mar_sel = 1'b1;
                            mem_sel = 1'b1;
                        end
                        OP_ST: begin
                            mar_sel = 1'b1;
                            mem_en  = 1'b1;
                        end
                        OP_JMP: begin
                            immed_sel = 1'b1;
                            pc_sel    = 1'b1;
                        end
                        OP_CMP: begin
                            alu_func = ALU_SUB;
                            flag_en  = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            S_WRITEBACK: begin
                clk_out = 1'b1;
                if (is_alu_op) begin
                    alu_func = ir;
                    w_en     = 1'b1;
                end else begin
                    case (ir)
                        OP_ADDI: begin
                            alu_func  = ALU_ADD;
                            immed_sel = 1'b1;
                            w_en      = 1'b1;
                        end
                        OP_LDI: begin
                            immed_sel = 1'b1;
                            w_en      = 1'b1;
                        end
                        OP_LD: begin
                            mem_sel = 1'b1;
                            w_en    = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit

module tb_control_unit;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] OP;
    logic       clk_out;
    logic       immed_sel;
    logic       w_en;
    logic [3:0] alu_func;
    logic       flag_en;
    logic       mem_sel;
    logic       mem_en;
    logic       pc_sel;
    logic       mar_sel;

    int errors = 0;
    int checks = 0;

    // {clk_out, immed_sel, w_en, alu_func[3:0], flag_en, mem_sel, mem_en, pc_sel, mar_sel}
    logic [11:0] outs;
    assign outs = {clk_out, immed_sel, w_en, alu_func, flag_en, mem_sel, mem_en, pc_sel, mar_sel};

    localparam logic [11:0] ZERO   = 12'b0_0_0_0000_0_0_0_0_0;
    localparam logic [11:0] CK     = 12'b1_0_0_0000_0_0_0_0_0;
    localparam logic [11:0] ADD_EX = 12'b1_0_0_0001_1_0_0_0_0;
    localparam logic [11:0] ADD_WB = 12'b1_0_1_0001_0_0_0_0_0;
    localparam logic [11:0] SUB_EX = 12'b1_0_0_0010_1_0_0_0_0;
    localparam logic [11:0] SUB_WB = 12'b1_0_1_0010_0_0_0_0_0;

    control_unit dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .OP        (OP),
        .clk_out   (clk_out),
        .immed_sel (immed_sel),
        .w_en      (w_en),
        .alu_func  (alu_func),
        .flag_en   (flag_en),
        .mem_sel   (mem_sel),
        .mem_en    (mem_en),
        .pc_sel    (pc_sel),
        .mar_sel   (mar_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [11:0] exp);
        checks++;
        assert (outs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, outs, exp);
        end
    endtask

    // Entered at a negedge while in FETCH; returns at a negedge in the next FETCH.
    task automatic do_instr(input string tag, input logic [3:0] op,
                            input logic [11:0] ex, input logic [11:0] wb);
        OP = op;
        tick();
        chk({tag, " decode"}, ZERO);
        tick();
        chk({tag, " execute"}, ex);
        OP = ~op;
        tick();
        chk({tag, " writeback"}, wb);
        tick();
        chk({tag, " next fetch"}, ZERO);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        OP  = 4'h0;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle after reset", ZERO);
        end

        en = 1'b1;
        tick();
        chk("first fetch", ZERO);
        do_instr("add", 4'h1, ADD_EX, ADD_WB);

        do_instr("nop",  4'h0, CK, CK);
        do_instr("add2", 4'h1, ADD_EX, ADD_WB);
        do_instr("sub",  4'h2, SUB_EX, SUB_WB);
        do_instr("and",  4'h3, 12'b1_0_0_0011_1_0_0_0_0, 12'b1_0_1_0011_0_0_0_0_0);
        do_instr("or",   4'h4, 12'b1_0_0_0100_1_0_0_0_0, 12'b1_0_1_0100_0_0_0_0_0);
        do_instr("xor",  4'h5, 12'b1_0_0_0101_1_0_0_0_0, 12'b1_0_1_0101_0_0_0_0_0);
        do_instr("not",  4'h6, 12'b1_0_0_0110_1_0_0_0_0, 12'b1_0_1_0110_0_0_0_0_0);
        do_instr("shl",  4'h7, 12'b1_0_0_0111_1_0_0_0_0, 12'b1_0_1_0111_0_0_0_0_0);
        do_instr("shr",  4'h8, 12'b1_0_0_1000_1_0_0_0_0, 12'b1_0_1_1000_0_0_0_0_0);
        do_instr("addi", 4'h9, 12'b1_1_0_0001_1_0_0_0_0, 12'b1_1_1_0001_0_0_0_0_0);
        do_instr("ldi",  4'hA, 12'b1_1_0_0000_0_0_0_0_0, 12'b1_1_1_0000_0_0_0_0_0);
        do_instr("ld",   4'hB, 12'b1_0_0_0000_0_1_0_0_1, 12'b1_0_1_0000_0_1_0_0_0);
        do_instr("st",   4'hC, 12'b1_0_0_0000_0_0_1_0_1, CK);
        do_instr("jmp",  4'hD, 12'b1_1_0_0000_0_0_0_1_0, CK);
        do_instr("cmp",  4'hE, 12'b1_0_0_0010_1_0_0_0_0, CK);

        OP = 4'hF;
        tick();
        chk("hlt decode", ZERO);
        tick();
        chk("hlt execute", CK);
        OP = 4'h1;
        for (int i = 0; i < 20; i++) begin
            en = i[0];
            tick();
            chk("halted", ZERO);
        end

        rst = 1'b1;
        en  = 1'b1;
        tick();
        chk("reset from halt", ZERO);
        rst = 1'b0;
        tick();
        chk("fetch after halt reset", ZERO);

        OP = 4'h1;
        tick();
        chk("drop-en decode", ZERO);
        tick();
        chk("drop-en execute", ADD_EX);
        en = 1'b0;
        tick();
        chk("drop-en writeback", ADD_WB);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drop-en idle", ZERO);
        end
        en = 1'b1;
        tick();
        chk("resume fetch", ZERO);
        OP = 4'h2;
        tick();
        chk("resume decode", ZERO);
        tick();
        chk("resume execute", SUB_EX);
        tick();
        chk("resume writeback", SUB_WB);
        tick();
        chk("resume next fetch", ZERO);

        OP = 4'h1;
        tick();
        chk("rst-wb decode", ZERO);
        tick();
        chk("rst-wb execute", ADD_EX);
        tick();
        chk("rst-wb writeback", ADD_WB);
        rst = 1'b1;
        tick();
        chk("rst-wb after reset edge", ZERO);
        rst = 1'b0;
        en  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst-wb idle", ZERO);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
